pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32 pipeline (F/D/E/M/W).

---
 rtl/pipeline_ctrl_pkg.sv | 47 ++++
 rtl/stall_counter.sv | 33 +++
 rtl/pipeline_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer:
// FSM state encodings, the per-stage control bundle and its canned values.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN      = 2'd0,
    PC_MC_WAIT  = 2'd1,
    PC_MEM_WAIT = 2'd2,
    PC_ERR      = 2'd3
  } pc_state_e;

  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic e_stall;
    logic m_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic w_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE     = 8'b0000_0000;
  localparam ctrl_t CTRL_FLUSH    = 8'b0000_1111;
  localparam ctrl_t CTRL_MC_HOLD  = 8'b1110_0010;
  localparam ctrl_t CTRL_MEM_HOLD = 8'b1111_0001;

  // Redirect beats the load-use hazard: the hazarding
  // instruction sits on the wrong path and gets flushed.
  function automatic ctrl_t flow_ctrl(
    input logic jump,
    input logic haz
  );
    ctrl_t c;
    c = CTRL_IDLE;
    if (jump) begin
      c.d_bubble = 1'b1;
      c.e_bubble = 1'b1;
    end else if (haz) begin
      c.f_stall  = 1'b1;
      c.d_stall  = 1'b1;
      c.e_bubble = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/stall_counter.sv
// Episode counter: load, saturating increment/decrement, match flag.
// Ports: clk, rst, load/load_val, inc, dec; hit = (cnt == HIT).
module stall_counter #(
  parameter int unsigned    W     = 2,
  parameter logic [W-1:0]   LIMIT = '1,
  parameter logic [W-1:0]   HIT   = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic         hit
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign hit = (cnt == HIT);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; drives F..W register
// enables. In: hazard, jump, mc_start, mem req/ready. Out: stalls, bubbles, timeout, state.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_hazard_D,
  input  logic       jump_E,
  input  logic       mc_start_E,
  input  logic       mem_req_M,
  input  logic       mem_ready_M,
  output logic       F_stall,
  output logic       D_stall,
  output logic       E_stall,
  output logic       M_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_bubble,
  output logic       mem_timeout,
  output logic [1:0] state_o
);

  localparam int unsigned MC_W   = $clog2(MUL_LAT);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  if (MUL_LAT < 2) begin : g_bad_mul_lat
    $error("pipeline_ctrl: MUL_LAT must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("pipeline_ctrl: TIMEOUT must be >= 1");
  end

  pc_state_e state, nxt;
  ctrl_t     ctrl;
  logic      err;
  logic      mc_load, mc_dec, mc_zero;
  logic      w_load, w_inc, w_limit;

  stall_counter #(
    .W     (MC_W),
    .LIMIT ({MC_W{1'b1}}),
    .HIT   ({MC_W{1'b0}})
  ) u_mc_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (mc_load),
    .load_val (MC_W'(MUL_LAT - 2)),
    .inc      (1'b0),
    .dec      (mc_dec),
    .hit      (mc_zero)
  );

  stall_counter #(
    .W     (WAIT_W),
    .LIMIT (WAIT_W'(TIMEOUT)),
    .HIT   (WAIT_W'(TIMEOUT))
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (WAIT_W'(1)),
    .inc      (w_inc),
    .dec      (1'b0),
    .hit      (w_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= PC_RUN;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = state;
    ctrl    = CTRL_IDLE;
    err     = 1'b0;
    mc_load = 1'b0;
    mc_dec  = 1'b0;
    w_load  = 1'b0;
    w_inc   = 1'b0;
    unique case (state)
      PC_RUN: begin
        if (mem_req_M && !mem_ready_M) begin
          ctrl   = CTRL_MEM_HOLD;
          w_load = 1'b1;
          nxt    = PC_MEM_WAIT;
        end else if (mc_start_E) begin
          ctrl    = CTRL_MC_HOLD;
          mc_load = 1'b1;
          nxt     = PC_MC_WAIT;
        end else begin
          ctrl = flow_ctrl(jump_E, data_hazard_D);
        end
      end
      PC_MC_WAIT: begin
        // Release cycle ignores mc_start_E: it is still the same op in E.
        if (!mc_zero) begin
          ctrl   = CTRL_MC_HOLD;
          mc_dec = 1'b1;
        end else begin
          ctrl = flow_ctrl(jump_E, data_hazard_D);
          nxt  = PC_RUN;
        end
      end
      PC_MEM_WAIT: begin
        // Ready on the limit cycle still completes normally.
        if (mem_ready_M) begin
          ctrl = flow_ctrl(jump_E, data_hazard_D);
          nxt  = PC_RUN;
        end else begin
          ctrl  = CTRL_MEM_HOLD;
          w_inc = 1'b1;
          if (w_limit) nxt = PC_ERR;
        end
      end
      PC_ERR: begin
        ctrl = CTRL_MEM_HOLD;
        err  = 1'b1;
      end
      default: nxt = PC_RUN;
    endcase
    if (rst) begin
      ctrl = CTRL_FLUSH;
      err  = 1'b0;
    end
  end

  assign {F_stall, D_stall, E_stall, M_stall,
          D_bubble, E_bubble, M_bubble, W_bubble} = ctrl;
  assign mem_timeout = err;
  assign state_o     = rst ? PC_RUN : state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vectors and episode sequences
// queue expectations that a negedge checker compares against two DUTs.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic haz = 1'b0;
  logic jmp = 1'b0;
  logic mc  = 1'b0;
  logic req = 1'b0;
  logic rdy = 1'b0;

  logic [7:0] ca, cb;
  logic       toa, tob;
  logic [1:0] sa, sb;

  pipeline_ctrl #(.MUL_LAT(4), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst),
    .data_hazard_D(haz), .jump_E(jmp), .mc_start_E(mc),
    .mem_req_M(req), .mem_ready_M(rdy),
    .F_stall(ca[7]), .D_stall(ca[6]), .E_stall(ca[5]), .M_stall(ca[4]),
    .D_bubble(ca[3]), .E_bubble(ca[2]), .M_bubble(ca[1]), .W_bubble(ca[0]),
    .mem_timeout(toa), .state_o(sa)
  );

  pipeline_ctrl #(.MUL_LAT(4), .TIMEOUT(3)) dut_b (
    .clk(clk), .rst(rst),
    .data_hazard_D(haz), .jump_E(jmp), .mc_start_E(mc),
    .mem_req_M(req), .mem_ready_M(rdy),
    .F_stall(cb[7]), .D_stall(cb[6]), .E_stall(cb[5]), .M_stall(cb[4]),
    .D_bubble(cb[3]), .E_bubble(cb[2]), .M_bubble(cb[1]), .W_bubble(cb[0]),
    .mem_timeout(tob), .state_o(sb)
  );

  // inputs: {rst, haz, jmp, mc, req, rdy}
  localparam logic [5:0] I0    = 6'b000000;
  localparam logic [5:0] I_RST = 6'b100000;
  localparam logic [5:0] I_HAZ = 6'b010000;
  localparam logic [5:0] I_JMP = 6'b001000;
  localparam logic [5:0] I_MC  = 6'b000100;
  localparam logic [5:0] I_REQ = 6'b000010;
  localparam logic [5:0] I_RDY = 6'b000001;

  // controls: {F,D,E,M stall, D,E,M,W bubble}
  localparam logic [7:0] C0    = 8'b0000_0000;
  localparam logic [7:0] FLUSH = 8'b0000_1111;
  localparam logic [7:0] CHAZ  = 8'b1100_0100;
  localparam logic [7:0] CJMP  = 8'b0000_1100;
  localparam logic [7:0] CMC   = 8'b1110_0010;
  localparam logic [7:0] CMEM  = 8'b1111_0001;

  typedef struct {
    string      name;
    logic [5:0] in;
    logic [7:0] ctrl;
    logic       to;
    logic [1:0] st;
    bit         use_b;
  } vec_t;

  vec_t q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic drive(input string name, input logic [5:0] in,
                       input logic [7:0] ctrl, input logic to,
                       input logic [1:0] st, input bit use_b);
    vec_t v;
    @(posedge clk);
    #1;
    {rst, haz, jmp, mc, req, rdy} = in;
    v.name  = name;
    v.in    = in;
    v.ctrl  = ctrl;
    v.to    = to;
    v.st    = st;
    v.use_b = use_b;
    q.push_back(v);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      vec_t       e;
      logic [10:0] got, exp;
      e   = q.pop_front();
      got = e.use_b ? {cb, tob, sb} : {ca, toa, sa};
      exp = {e.ctrl, e.to, e.st};
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got ctrl=%b to=%b st=%0d, expected ctrl=%b to=%b st=%0d",
                    e.name, got[10:3], got[2], got[1:0],
                    exp[10:3], exp[2], exp[1:0]);
    end
  end

  vec_t tbl[8];

  initial begin
    tbl[0] = '{"rst0",     I_RST,                 FLUSH, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{"rst_busy", I_RST | I_HAZ | I_REQ, FLUSH, 1'b0, 2'd0, 1'b1};
    tbl[2] = '{"idle",     I0,                    C0,    1'b0, 2'd0, 1'b0};
    tbl[3] = '{"haz",      I_HAZ,                 CHAZ,  1'b0, 2'd0, 1'b0};
    tbl[4] = '{"haz_off",  I0,                    C0,    1'b0, 2'd0, 1'b0};
    tbl[5] = '{"haz_jmp",  I_HAZ | I_JMP,         CJMP,  1'b0, 2'd0, 1'b0};
    tbl[6] = '{"jmp",      I_JMP,                 CJMP,  1'b0, 2'd0, 1'b1};
    tbl[7] = '{"idle2",    I0,                    C0,    1'b0, 2'd0, 1'b1};

    for (int i = 0; i < 8; i++)
      drive(tbl[i].name, tbl[i].in, tbl[i].ctrl, tbl[i].to, tbl[i].st, tbl[i].use_b);

    // multi-cycle op: 3 stall cycles, release in the 4th
    drive("mc1", I_MC, CMC, 1'b0, 2'd0, 1'b0);
    drive("mc2", I_MC, CMC, 1'b0, 2'd1, 1'b0);
    drive("mc3", I_MC, CMC, 1'b0, 2'd1, 1'b0);
    drive("mc_rel", I_MC, C0, 1'b0, 2'd1, 1'b0);
    drive("mc_after", I0, C0, 1'b0, 2'd0, 1'b0);

    // jump held across a multi-cycle op is serviced on release
    drive("mcj1", I_MC | I_JMP, CMC, 1'b0, 2'd0, 1'b0);
    drive("mcj2", I_MC | I_JMP, CMC, 1'b0, 2'd1, 1'b0);
    drive("mcj3", I_MC | I_JMP, CMC, 1'b0, 2'd1, 1'b0);
    drive("mcj_rel", I_MC | I_JMP, CJMP, 1'b0, 2'd1, 1'b0);
    drive("mcj_after", I0, C0, 1'b0, 2'd0, 1'b0);

    // reset mid-episode
    drive("mcr1", I_MC, CMC, 1'b0, 2'd0, 1'b0);
    drive("mcr_rst", I_RST, FLUSH, 1'b0, 2'd0, 1'b0);
    drive("mcr_after", I0, C0, 1'b0, 2'd0, 1'b0);

    // memory wait, 5 stall cycles
    drive("mem1", I_REQ, CMEM, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      drive("mem_wait", I_REQ, CMEM, 1'b0, 2'd2, 1'b0);
    drive("mem_rel", I_REQ | I_RDY, C0, 1'b0, 2'd2, 1'b0);
    drive("mem_after", I0, C0, 1'b0, 2'd0, 1'b0);

    // memory wait with a jump held throughout
    drive("memj1", I_REQ | I_JMP, CMEM, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      drive("memj_wait", I_REQ | I_JMP, CMEM, 1'b0, 2'd2, 1'b0);
    drive("memj_rel", I_REQ | I_RDY | I_JMP, CJMP, 1'b0, 2'd2, 1'b0);
    drive("memj_after", I0, C0, 1'b0, 2'd0, 1'b0);

    // dut_b timed out during the above; reset both
    drive("b_in_err", I0, CMEM, 1'b1, 2'd3, 1'b1);
    drive("b_rst", I_RST, FLUSH, 1'b0, 2'd0, 1'b1);
    drive("b_idle", I0, C0, 1'b0, 2'd0, 1'b1);

    // TIMEOUT=3: ERR after 4 stall cycles, sticky until reset
    drive("to1", I_REQ, CMEM, 1'b0, 2'd0, 1'b1);
    drive("to2", I_REQ, CMEM, 1'b0, 2'd2, 1'b1);
    drive("to3", I_REQ, CMEM, 1'b0, 2'd2, 1'b1);
    drive("to4", I_REQ, CMEM, 1'b0, 2'd2, 1'b1);
    drive("to_err", I0, CMEM, 1'b1, 2'd3, 1'b1);
    drive("to_sticky", I_RDY, CMEM, 1'b1, 2'd3, 1'b1);
    drive("to_rst", I_RST, FLUSH, 1'b0, 2'd0, 1'b1);
    drive("to_clear", I0, C0, 1'b0, 2'd0, 1'b1);

    // ready on the limit cycle wins
    drive("lim1", I_REQ, CMEM, 1'b0, 2'd0, 1'b1);
    drive("lim2", I_REQ, CMEM, 1'b0, 2'd2, 1'b1);
    drive("lim3", I_REQ, CMEM, 1'b0, 2'd2, 1'b1);
    drive("lim_rdy", I_REQ | I_RDY, C0, 1'b0, 2'd2, 1'b1);
    drive("lim_after", I0, C0, 1'b0, 2'd0, 1'b1);
    drive("lim_after_a", I0, C0, 1'b0, 2'd0, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
